// File: rtl/sap2_core.sv
// sap2_core: parametrised accumulator CPU (SAP-1 successor).
//   Microsequencer T0..T4 + HALT, carry/zero flags, conditional jumps,
//   immediate load, store-to-memory, output register with strobe.
// Ports:
//   sysclk, reset (sync, active-high), clken (step enable)
//   fp_prog/fp_write/fp_adr/fp_data : front-panel programming
//   fp_rdata   : combinational mem[fp_adr]
//   o_out      : output register, out_strobe pulses when it loads
//   halt, flag_c, flag_z, pc_value, ir_value : status / debug
module sap2_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clken,
  input  logic              fp_prog,
  input  logic              fp_write,
  input  logic [ADDR_W-1:0] fp_adr,
  input  logic [DATA_W-1:0] fp_data,
  output logic [DATA_W-1:0] fp_rdata,
  output logic [DATA_W-1:0] o_out,
  output logic              out_strobe,
  output logic              halt,
  output logic              flag_c,
  output logic              flag_z,
  output logic [ADDR_W-1:0] pc_value,
  output logic [DATA_W-1:0] ir_value
);

  typedef enum logic [2:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } op_e;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              strobe_q, strobe_d;

  logic              advance;
  logic              mem_we;
  op_e               opc;
  logic [ADDR_W-1:0] opd;
  logic              is_sub;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] bus_mem;

  assign advance = clken & ~fp_prog;
  assign opc     = op_e'(ir_q[DATA_W-1 -: 4]);
  assign opd     = ir_q[ADDR_W-1:0];
  assign bus_mem = mem_q[mar_q];

  // SUB is A + ~B + 1, so carry-out doubles as "no borrow".
  assign is_sub  = (opc == OP_SUB);
  assign alu_sum = {1'b0, a_q}
                 + {1'b0, (is_sub ? ~b_q : b_q)}
                 + {{DATA_W{1'b0}}, is_sub};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    c_d      = c_q;
    z_d      = z_q;
    strobe_d = 1'b0;
    mem_we   = 1'b0;
    if (advance) begin
      case (state_q)
        S_T0: begin
          mar_d   = pc_q;
          state_d = S_T1;
        end
        S_T1: begin
          ir_d    = bus_mem;
          pc_d    = pc_q + 1'b1;
          state_d = S_T2;
        end
        S_T2: begin
          state_d = S_T0;
          case (opc)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_d   = opd;
              state_d = S_T3;
            end
            OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, opd};
            OP_JMP: pc_d = opd;
            OP_JC:  if (c_q) pc_d = opd;
            OP_JZ:  if (z_q) pc_d = opd;
            OP_OUT: begin
              out_d    = a_q;
              strobe_d = 1'b1;
            end
            OP_HLT: state_d = S_HALT;
            default: ;
          endcase
        end
        S_T3: begin
          state_d = S_T0;
          case (opc)
            OP_LDA: a_d = bus_mem;
            OP_STA: mem_we = ~reset;
            OP_ADD, OP_SUB: begin
              b_d     = bus_mem;
              state_d = S_T4;
            end
            default: ;
          endcase
        end
        S_T4: begin
          a_d     = alu_sum[DATA_W-1:0];
          c_d     = alu_sum[DATA_W];
          z_d     = (alu_sum[DATA_W-1:0] == '0);
          state_d = S_T0;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_T0;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= S_T0;
      pc_q     <= '0;
      mar_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      c_q      <= c_d;
      z_q      <= z_d;
      strobe_q <= strobe_d;
    end
  end

  // Memory has no reset; front-panel writes go through even during reset.
  always_ff @(posedge sysclk) begin
    if (fp_prog && fp_write)
      mem_q[fp_adr] <= fp_data;
    else if (mem_we)
      mem_q[mar_q] <= a_q;
  end

  assign fp_rdata   = mem_q[fp_adr];
  assign o_out      = out_q;
  assign out_strobe = strobe_q;
  assign halt       = (state_q == S_HALT);
  assign flag_c     = c_q;
  assign flag_z     = z_q;
  assign pc_value   = pc_q;
  assign ir_value   = ir_q;

endmodule

// File: tb/tb_sap2_core.sv
// tb_sap2_core: directed bench for sap2_core, 8/4 default instance plus a
// 12/6 instance for the width-scaled program.
module tb_sap2_core;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit data / 4-bit address instance
  logic       rst, clken, fp_prog, fp_write;
  logic [3:0] fp_adr;
  logic [7:0] fp_data;
  logic [7:0] fp_rdata, o_out, ir_value;
  logic       out_strobe, halt, flag_c, flag_z;
  logic [3:0] pc_value;

  sap2_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .sysclk(clk), .reset(rst), .clken(clken), .fp_prog(fp_prog),
    .fp_write(fp_write), .fp_adr(fp_adr), .fp_data(fp_data),
    .fp_rdata(fp_rdata), .o_out(o_out), .out_strobe(out_strobe),
    .halt(halt), .flag_c(flag_c), .flag_z(flag_z),
    .pc_value(pc_value), .ir_value(ir_value)
  );

  // 12-bit data / 6-bit address instance
  logic        rst12, clken12, fp_prog12, fp_write12;
  logic [5:0]  fp_adr12;
  logic [11:0] fp_data12;
  logic [11:0] fp_rdata12, o_out12, ir_value12;
  logic        out_strobe12, halt12, flag_c12, flag_z12;
  logic [5:0]  pc_value12;

  sap2_core #(.DATA_W(12), .ADDR_W(6)) dut12 (
    .sysclk(clk), .reset(rst12), .clken(clken12), .fp_prog(fp_prog12),
    .fp_write(fp_write12), .fp_adr(fp_adr12), .fp_data(fp_data12),
    .fp_rdata(fp_rdata12), .o_out(o_out12), .out_strobe(out_strobe12),
    .halt(halt12), .flag_c(flag_c12), .flag_z(flag_z12),
    .pc_value(pc_value12), .ir_value(ir_value12)
  );

  int vecs = 0;
  int errs = 0;
  int nstrobe = 0;
  logic [7:0] outs [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_strobe) begin
      nstrobe++;
      outs.push_back(o_out);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    fp_prog = 1'b1; fp_write = 1'b1; fp_adr = a; fp_data = d;
    tick();
    fp_write = 1'b0; fp_prog = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nstrobe = 0;
    outs.delete();
  endtask

  task automatic step(input int n);
    clken = 1'b1;
    repeat (n) tick();
    clken = 1'b0;
  endtask

  task automatic run_halt(input int budget, output int edges);
    edges = 0;
    clken = 1'b1;
    while (!halt && edges < budget) begin
      tick();
      edges++;
    end
    clken = 1'b0;
    check("halt_reached", {31'b0, halt}, 32'd1);
  endtask

  int edges;

  initial begin
    rst = 1'b0; clken = 1'b0; fp_prog = 1'b0; fp_write = 1'b0;
    fp_adr = '0; fp_data = '0;
    rst12 = 1'b0; clken12 = 1'b0; fp_prog12 = 1'b0; fp_write12 = 1'b0;
    fp_adr12 = '0; fp_data12 = '0;
    tick();
    for (int unsigned i = 0; i < 16; i++) load(4'(i), 8'h00);

    // 1: LDA 9; ADD 10; OUT; HLT  -> 0x10 + 0x0E = 0x1E in 15 edges
    load(4'd0, 8'h19); load(4'd1, 8'h2A); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
    load(4'd9, 8'h10); load(4'd10, 8'h0E);
    do_reset();
    check("rst_pc", {28'b0, pc_value}, 32'h0);
    check("rst_ir", {24'b0, ir_value}, 32'h0);
    check("rst_out", {24'b0, o_out}, 32'h0);
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_flags", {30'b0, flag_c, flag_z}, 32'h0);
    step(14);
    check("s1_halt_at14", {31'b0, halt}, 32'd0);
    step(1);
    check("s1_halt_at15", {31'b0, halt}, 32'd1);
    check("s1_strobes", nstrobe, 32'd1);
    check("s1_out", {24'b0, o_out}, 32'h1E);
    check("s1_flags", {30'b0, flag_c, flag_z}, 32'h0);
    step(5);
    check("s1_halt_sticky", {31'b0, halt}, 32'd1);

    // 2a: LDI 5; SUB 15 (=5); OUT; HLT -> 0, Z=1, C=1
    load(4'd0, 8'h55); load(4'd1, 8'h3F); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
    load(4'd15, 8'h05);
    do_reset();
    run_halt(40, edges);
    check("s2a_out", {24'b0, o_out}, 32'h00);
    check("s2a_cz", {30'b0, flag_c, flag_z}, 32'b11);
    // 2b: LDI 3; SUB 15 -> 0xFE, borrow so C=0, Z=0
    load(4'd0, 8'h53);
    do_reset();
    run_halt(40, edges);
    check("s2b_out", {24'b0, o_out}, 32'hFE);
    check("s2b_cz", {30'b0, flag_c, flag_z}, 32'b00);
    // 2c: LDA 14 (0xF0); ADD 15 (0x20) -> 0x10, C=1, Z=0
    load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd14, 8'hF0); load(4'd15, 8'h20);
    do_reset();
    run_halt(40, edges);
    check("s2c_out", {24'b0, o_out}, 32'h10);
    check("s2c_cz", {30'b0, flag_c, flag_z}, 32'b10);

    // 3: countdown loop
    load(4'd0, 8'h1E); load(4'd1, 8'h3F); load(4'd2, 8'h4E); load(4'd3, 8'hE0);
    load(4'd4, 8'h86); load(4'd5, 8'h61); load(4'd6, 8'hF0);
    load(4'd14, 8'h03); load(4'd15, 8'h01);
    do_reset();
    run_halt(200, edges);
    check("s3_strobes", nstrobe, 32'd3);
    if (outs.size() == 3) begin
      check("s3_out0", {24'b0, outs[0]}, 32'h02);
      check("s3_out1", {24'b0, outs[1]}, 32'h01);
      check("s3_out2", {24'b0, outs[2]}, 32'h00);
    end
    fp_adr = 4'd14; #1;
    check("s3_mem14", {24'b0, fp_rdata}, 32'h00);
    check("s3_z", {31'b0, flag_z}, 32'd1);

    // 4: JMP 14; 14: LDI 7; 15: NOP wraps to 0; then patch 0/1 to OUT/HLT
    load(4'd0, 8'h6E); load(4'd14, 8'h57); load(4'd15, 8'h00);
    do_reset();
    step(3);
    check("s4_pc_jmp", {28'b0, pc_value}, 32'd14);
    load(4'd0, 8'hE0); load(4'd1, 8'hF0);
    check("s4_pc_frozen", {28'b0, pc_value}, 32'd14);
    step(3);
    check("s4_pc15", {28'b0, pc_value}, 32'd15);
    step(2);
    check("s4_pc_wrap", {28'b0, pc_value}, 32'd0);
    check("s4_ir_nop", {24'b0, ir_value}, 32'h00);
    run_halt(20, edges);
    check("s4_out", {24'b0, o_out}, 32'h07);
    check("s4_edges", edges, 32'd7);

    // 5: LDI 3; ADD 15 (4); NOP; OUT; HLT with clken/fp_prog gating mid-ADD
    load(4'd0, 8'h53); load(4'd1, 8'h2F); load(4'd2, 8'h00); load(4'd3, 8'hE0);
    load(4'd4, 8'hF0); load(4'd15, 8'h04);
    do_reset();
    step(6);
    clken = 1'b0;
    repeat (20) tick();
    check("s5_hold_pc", {28'b0, pc_value}, 32'd2);
    check("s5_hold_ir", {24'b0, ir_value}, 32'h2F);
    check("s5_hold_out", {24'b0, o_out}, 32'h00);
    fp_prog = 1'b1; clken = 1'b1;
    fp_write = 1'b1; fp_adr = 4'd2; fp_data = 8'hAB;
    tick();
    fp_write = 1'b0;
    repeat (3) tick();
    check("s5_fp_rdata", {24'b0, fp_rdata}, 32'hAB);
    check("s5_frz_pc", {28'b0, pc_value}, 32'd2);
    check("s5_frz_ir", {24'b0, ir_value}, 32'h2F);
    fp_prog = 1'b0; clken = 1'b0;
    run_halt(30, edges);
    check("s5_edges", edges, 32'd11);
    check("s5_out", {24'b0, o_out}, 32'h07);
    check("s5_cz", {30'b0, flag_c, flag_z}, 32'b00);
    fp_write = 1'b1; fp_adr = 4'd15; fp_data = 8'h99;
    tick();
    fp_write = 1'b0; #1;
    check("s5_fpw_ignored", {24'b0, fp_rdata}, 32'h04);

    // 6: LDA 14; ADD 14 (0x90+0x90); OUT; STA 13 -> reset in STA T2
    load(4'd0, 8'h1E); load(4'd1, 8'h2E); load(4'd2, 8'hE0); load(4'd3, 8'h4D);
    load(4'd4, 8'hF0); load(4'd13, 8'h55); load(4'd14, 8'h90);
    do_reset();
    step(14);
    check("s6_pre_out", {24'b0, o_out}, 32'h20);
    check("s6_pre_c", {31'b0, flag_c}, 32'd1);
    clken = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; clken = 1'b0;
    tick();
    check("s6_rst_pc", {28'b0, pc_value}, 32'h0);
    check("s6_rst_ir", {24'b0, ir_value}, 32'h0);
    check("s6_rst_out", {24'b0, o_out}, 32'h0);
    check("s6_rst_flags", {30'b0, flag_c, flag_z}, 32'h0);
    fp_adr = 4'd13; #1;
    check("s6_mem13_kept", {24'b0, fp_rdata}, 32'h55);
    rst = 1'b1; fp_prog = 1'b1; fp_write = 1'b1; fp_adr = 4'd12; fp_data = 8'h77;
    tick();
    rst = 1'b0; fp_prog = 1'b0; fp_write = 1'b0; #1;
    check("s6_fpw_in_rst", {24'b0, fp_rdata}, 32'h77);
    step(2);
    check("s6_restart_pc", {28'b0, pc_value}, 32'd1);
    check("s6_restart_ir", {24'b0, ir_value}, 32'h1E);

    // 12/6 instance: LDA 41; ADD 42; OUT; HLT -> 0x7F0 + 0x80E = 0xFFE
    begin
      logic [5:0]  a12 [6];
      logic [11:0] d12 [6];
      int          ns12;
      a12 = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd41, 6'd42};
      d12 = '{12'h129, 12'h22A, 12'hE00, 12'hF00, 12'h7F0, 12'h80E};
      fp_prog12 = 1'b1; fp_write12 = 1'b1;
      for (int unsigned i = 0; i < 6; i++) begin
        fp_adr12 = a12[i]; fp_data12 = d12[i];
        tick();
      end
      fp_write12 = 1'b0; fp_prog12 = 1'b0;
      rst12 = 1'b1;
      tick();
      rst12 = 1'b0;
      check("w12_rst_out", {20'b0, o_out12}, 32'h0);
      ns12 = 0;
      clken12 = 1'b1;
      for (int unsigned i = 0; i < 14; i++) begin
        tick();
        if (out_strobe12) ns12++;
      end
      check("w12_halt_at14", {31'b0, halt12}, 32'd0);
      tick();
      if (out_strobe12) ns12++;
      clken12 = 1'b0;
      check("w12_halt_at15", {31'b0, halt12}, 32'd1);
      check("w12_strobes", ns12, 32'd1);
      check("w12_out", {20'b0, o_out12}, 32'hFFE);
      check("w12_flags", {30'b0, flag_c12, flag_z12}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
